// File: rtl/uart_mem_dump_if.sv
// RAM read-port borrow bus: request/grant handshake plus synchronous read data.
interface uart_mem_dump_if #(
  parameter int ADDR_WIDTH = 11
);
  logic                  ask_for_ram;
  logic                  ram_grant;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [7:0]            rdata;

  modport master (
    output ask_for_ram,
    output raddr,
    input  ram_grant,
    input  rdata
  );

  modport slave (
    input  ask_for_ram,
    input  raddr,
    output ram_grant,
    output rdata
  );
endinterface

// File: rtl/uart_mem_dump.sv
// Streams a RAM window out of a UART TX line as 8N1 frames, led by one sync byte.
// Each RAM byte is fetched by borrowing the read port through the ask/grant bus.
module uart_mem_dump #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          ADDR_WIDTH   = 11,
  parameter int          START_ADDR   = 0,
  parameter int          LENGTH       = 2048,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  uart_mem_dump_if.master   ram,
  output logic              serial_txd,
  output logic              busy,
  output logic              done
);

  localparam int                    BAUD_W     = $clog2(CLKS_PER_BIT + 1);
  localparam logic [BAUD_W-1:0]     BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  // One extra bit so a full 2^ADDR_WIDTH window still reaches its terminal count.
  localparam logic [ADDR_WIDTH:0]   LEN_CNT    = (ADDR_WIDTH + 1)'(LENGTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST = ADDR_WIDTH'(START_ADDR);

  typedef enum logic [2:0] {
    IDLE,
    SEND_SYNC,
    REQ,
    CAP,
    SEND,
    FINISH
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [3:0]            bit_idx;
  logic [7:0]            shreg;
  logic [ADDR_WIDTH:0]   byte_cnt;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  ask;
  logic                  sending;
  logic                  bit_end;
  logic                  frame_end;
  logic                  tx_bit;
  logic [9:0]            frame;

  assign ram.ask_for_ram = ask;
  assign ram.raddr       = raddr;

  // Next-state selection and the line level for the bit currently being timed.
  always_comb begin
    state_nxt = state;
    sending   = (state == SEND_SYNC) || (state == SEND);
    bit_end   = sending && (baud_cnt == BAUD_LAST);
    frame_end = bit_end && (bit_idx == 4'd9);
    frame     = {1'b1, shreg, 1'b0};
    tx_bit    = sending ? frame[bit_idx] : 1'b1;
    case (state)
      IDLE:            if (start) state_nxt = SEND_SYNC;
      SEND_SYNC, SEND: if (frame_end) state_nxt = (byte_cnt == LEN_CNT) ? FINISH : REQ;
      REQ:             if (ram.ram_grant) state_nxt = CAP;
      CAP:             state_nxt = SEND;
      FINISH:          state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Bit timing, shift data, RAM address/count and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      serial_txd <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      ask        <= 1'b0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_cnt   <= '0;
      raddr      <= ADDR_FIRST;
    end else begin
      // Registered line: the level chosen this cycle appears on the next one.
      serial_txd <= tx_bit;
      done       <= (state_nxt == FINISH);
      if (state == FINISH) busy <= 1'b0;

      if (bit_end) begin
        baud_cnt <= '0;
        bit_idx  <= frame_end ? 4'd0 : bit_idx + 4'd1;
      end else if (sending) begin
        baud_cnt <= baud_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            shreg    <= SYNC_BYTE;
            busy     <= 1'b1;
            byte_cnt <= '0;
            raddr    <= ADDR_FIRST;
            baud_cnt <= '0;
            bit_idx  <= '0;
          end
        end
        SEND_SYNC, SEND: begin
          // Request the port on the same edge the frame ends to keep the gap minimal.
          if (frame_end && (byte_cnt != LEN_CNT)) ask <= 1'b1;
        end
        CAP: begin
          shreg    <= ram.rdata;
          ask      <= 1'b0;
          byte_cnt <= byte_cnt + 1'b1;
          raddr    <= raddr + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_dump.sv
// Bench for uart_mem_dump: a small window with address wrap and a full 2^ADDR_WIDTH window.
module tb_uart_mem_dump;

  localparam int CPB_A   = 4;
  localparam int AW_A    = 4;
  localparam int START_A = 14;
  localparam int LEN_A   = 4;
  localparam int CPB_B   = 2;
  localparam int AW_B    = 11;
  localparam int LEN_B   = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic start_a, start_b;
  logic txd_a, busy_a, done_a;
  logic txd_b, busy_b, done_b;

  uart_mem_dump_if #(.ADDR_WIDTH(AW_A)) bus_a ();
  uart_mem_dump_if #(.ADDR_WIDTH(AW_B)) bus_b ();

  uart_mem_dump #(
    .CLKS_PER_BIT(CPB_A), .ADDR_WIDTH(AW_A), .START_ADDR(START_A),
    .LENGTH(LEN_A), .SYNC_BYTE(8'hA5)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .ram(bus_a),
    .serial_txd(txd_a), .busy(busy_a), .done(done_a)
  );

  uart_mem_dump #(
    .CLKS_PER_BIT(CPB_B), .ADDR_WIDTH(AW_B), .START_ADDR(0),
    .LENGTH(LEN_B), .SYNC_BYTE(8'hA5)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .ram(bus_b),
    .serial_txd(txd_b), .busy(busy_b), .done(done_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RAM A: synchronous read, grant follows ask one cycle later unless a hold is armed.
  logic [7:0] mem_a [16];
  int   req_no_a   = 0;
  int   wait_a     = 0;
  int   hold_req_a = -1;
  int   hold_len_a = 0;
  bit   hold_bad_a = 0;
  logic ask_q_a    = 1'b0;
  int   addr_log_a [$];

  always @(posedge clk) begin
    bit holding;
    if (bus_a.ram_grant) bus_a.rdata <= mem_a[bus_a.raddr];
    if (bus_a.ask_for_ram && !ask_q_a) begin
      req_no_a++;
      wait_a = 0;
      addr_log_a.push_back(int'(bus_a.raddr));
    end
    holding = (req_no_a == hold_req_a) && (wait_a < hold_len_a);
    if (holding && (txd_a !== 1'b1 || bus_a.ask_for_ram !== 1'b1)) hold_bad_a = 1;
    bus_a.ram_grant <= bus_a.ask_for_ram && !holding;
    if (bus_a.ask_for_ram) wait_a++;
    ask_q_a = bus_a.ask_for_ram;
  end

  // RAM B: contents equal the low address byte, immediate one-cycle grant.
  always @(posedge clk) begin
    if (bus_b.ram_grant) bus_b.rdata <= bus_b.raddr[7:0];
    bus_b.ram_grant <= bus_b.ask_for_ram;
  end

  // done/busy observers
  int   done_cnt_a = 0;
  int   done_cnt_b = 0;
  logic done_q_a   = 1'b0;
  logic busy_at_done_a    = 1'b0;
  logic busy_after_done_a = 1'b1;
  always @(negedge clk) begin
    if (done_a === 1'b1) begin
      done_cnt_a++;
      busy_at_done_a = busy_a;
    end
    if (done_q_a === 1'b1) busy_after_done_a = busy_a;
    done_q_a = done_a;
    if (done_b === 1'b1) done_cnt_b++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] expand(input logic [7:0] b, input int cpb);
    logic [9:0]  f;
    logic [63:0] r;
    f = {1'b1, b, 1'b0};
    r = '0;
    for (int k = 0; k < 10 * cpb; k++) r[k] = f[k / cpb];
    return r;
  endfunction

  // Wait for a start bit, then record one line sample per clock for a whole frame.
  task automatic get_frame(input bit sel, input int cpb, output logic [63:0] v, output bit ok);
    int n;
    v  = '0;
    ok = 0;
    n  = 0;
    @(negedge clk);
    while ((sel ? txd_b : txd_a) !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) return;
    for (int k = 0; k < 10 * cpb; k++) begin
      v[k] = sel ? txd_b : txd_a;
      if (k < 10 * cpb - 1) @(negedge clk);
    end
    ok = 1;
  endtask

  task automatic pulse_a();
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
  endtask

  task automatic fill_mem_a();
    for (int i = 0; i < 16; i++) mem_a[i] = 8'($urandom_range(0, 255));
  endtask

  // Reference: sync byte, then RAM bytes from START_A onward wrapping at 16 entries.
  task automatic dump_a(input string tg);
    logic [7:0]  exp_q [$];
    logic [63:0] v;
    bit          ok;
    exp_q = {8'hA5};
    for (int i = 0; i < LEN_A; i++) exp_q.push_back(mem_a[(START_A + i) % 16]);
    for (int i = 0; i <= LEN_A; i++) begin
      get_frame(0, CPB_A, v, ok);
      chk($sformatf("%s_frame%0d_seen", tg, i), 64'(ok), 64'd1);
      if (!ok) break;
      chk($sformatf("%s_frame%0d", tg, i), v, expand(exp_q[i], CPB_A));
    end
  endtask

  task automatic quiet_a(input int n, input string tg);
    int lows = 0;
    repeat (n) begin
      @(negedge clk);
      if (txd_a !== 1'b1) lows++;
    end
    chk(tg, 64'(lows), 64'd0);
  endtask

  task automatic check_addrs(input int from, input string tg);
    chk({tg, "_addr_count"}, 64'(addr_log_a.size() - from), 64'(LEN_A));
    for (int i = 0; i < LEN_A && from + i < addr_log_a.size(); i++)
      chk($sformatf("%s_raddr%0d", tg, i), 64'(addr_log_a[from + i]), 64'((START_A + i) % 16));
  endtask

  task automatic finish_checks_a(input int done0, input string tg);
    repeat (4) @(negedge clk);
    chk({tg, "_done_pulses"}, 64'(done_cnt_a - done0), 64'd1);
    chk({tg, "_busy_at_done"}, 64'(busy_at_done_a), 64'd1);
    chk({tg, "_busy_after_done"}, 64'(busy_after_done_a), 64'd0);
    quiet_a(60, {tg, "_no_extra_frame"});
  endtask

  initial begin
    int          d0, l0, n;
    logic [63:0] v;
    logic [7:0]  lb;
    bit          ok;

    reset_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    fill_mem_a();
    repeat (3) @(negedge clk);
    chk("rst_txd", 64'(txd_a), 64'd1);
    chk("rst_ask", 64'(bus_a.ask_for_ram), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_raddr", 64'(bus_a.raddr), 64'(START_A));
    chk("rst_txd_b", 64'(txd_b), 64'd1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Plain dump with immediate grant, wrapping address window.
    d0 = done_cnt_a;
    l0 = addr_log_a.size();
    pulse_a();
    chk("t1_busy_after_start", 64'(busy_a), 64'd1);
    dump_a("t1");
    finish_checks_a(d0, "t1");
    check_addrs(l0, "t1");

    // Grant withheld 50 cycles in the second request, plus a stray start mid-dump.
    fill_mem_a();
    d0 = done_cnt_a;
    l0 = addr_log_a.size();
    hold_req_a = req_no_a + 2;
    hold_len_a = 50;
    pulse_a();
    fork
      begin
        repeat ($urandom_range(30, 150)) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
      end
      dump_a("t2");
    join
    finish_checks_a(d0, "t2");
    check_addrs(l0, "t2");
    chk("t2_hold_line_and_ask", 64'(hold_bad_a), 64'd0);
    hold_req_a = -1;

    // Reset during bit 5 of the second frame, then a fresh complete dump.
    fill_mem_a();
    pulse_a();
    get_frame(0, CPB_A, v, ok);
    chk("t3_sync_frame", v, expand(8'hA5, CPB_A));
    n = 0;
    @(negedge clk);
    while (txd_a !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("t3_second_frame_seen", 64'(n < 400), 64'd1);
    repeat (5 * CPB_A + 1) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t3_async_txd", 64'(txd_a), 64'd1);
    chk("t3_async_ask", 64'(bus_a.ask_for_ram), 64'd0);
    chk("t3_async_busy", 64'(busy_a), 64'd0);
    chk("t3_async_raddr", 64'(bus_a.raddr), 64'(START_A));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    quiet_a(20, "t3_no_resume");
    fill_mem_a();
    d0 = done_cnt_a;
    l0 = addr_log_a.size();
    pulse_a();
    dump_a("t3");
    finish_checks_a(d0, "t3");
    check_addrs(l0, "t3");

    // Full 2^ADDR_WIDTH window, contents equal to the low address byte.
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    lb = '0;
    for (int i = 0; i <= LEN_B; i++) begin
      logic [7:0] eb;
      eb = (i == 0) ? 8'hA5 : 8'((i - 1) % 256);
      get_frame(1, CPB_B, v, ok);
      chk($sformatf("tb_frame%0d_seen", i), 64'(ok), 64'd1);
      if (!ok) break;
      chk($sformatf("tb_frame%0d", i), v, expand(eb, CPB_B));
      for (int j = 0; j < 8; j++) lb[j] = v[CPB_B * (j + 1)];
    end
    chk("tb_last_byte", 64'(lb), 64'hFF);
    repeat (4) @(negedge clk);
    chk("tb_done_pulses", 64'(done_cnt_b), 64'd1);
    chk("tb_busy_end", 64'(busy_b), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
